// File: rtl/image_pixel_streamer.sv
// Frame source: holds one IMG_W x IMG_H grayscale image in RAM and streams it in raster order
// over valid/ready with sof/eol/eof markers. Define PIXEL_STREAMER_PAD_EN for a 1-pixel zero border.
module image_pixel_streamer #(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              start,
  output logic              busy,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              frame_done
);

`ifdef PIXEL_STREAMER_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int OUT_W = IMG_W + 2 * PAD;
  localparam int OUT_H = IMG_H + 2 * PAD;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int AW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW    = $clog2(OUT_W);
  localparam int RW    = $clog2(OUT_H);
  localparam logic [ADDR_W-1:0] NPIX_A = ADDR_W'(NPIX);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

  state_t            state, state_nx;
  logic              xfer, issue;
  logic [1:0]        occ;
  logic              wr_ok;

  logic [PIX_W-1:0]  mem [NPIX];
  logic [PIX_W-1:0]  ram_q;
  logic              rd_pending, rd_zero;
  logic [PIX_W-1:0]  in_data;

  logic [CW-1:0]     fcol, ocol;
  logic [RW-1:0]     frow, orow;
  logic [AW-1:0]     raddr;
  logic              fetch_done, f_last, f_border, o_last;

  logic              skid_valid;
  logic [PIX_W-1:0]  skid_data;

  assign xfer   = pix_valid && pix_ready;
  assign wr_ok  = wr_en && !busy && (wr_addr < NPIX_A);
  assign f_last = (fcol == CW'(OUT_W - 1)) && (frow == RW'(OUT_H - 1));
  assign o_last = (ocol == CW'(OUT_W - 1)) && (orow == RW'(OUT_H - 1));
  assign occ    = 2'(pix_valid) + 2'(skid_valid) + 2'(rd_pending);

`ifdef PIXEL_STREAMER_PAD_EN
  assign f_border = (frow == '0) || (frow == RW'(OUT_H - 1)) ||
                    (fcol == '0) || (fcol == CW'(OUT_W - 1));
`else
  assign f_border = 1'b0;
`endif

  // FSM state register
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of a combinational block is given a default first, so no latch is inferred.
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    issue      = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH: begin
        busy     = 1'b1;
        issue    = 1'b1;
        state_nx = S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        // Prefetch only while the output reg + skid entry can absorb what is in flight.
        issue = !fetch_done && ((occ < 2'd2) || (occ == 2'd2 && xfer));
        if (xfer && o_last) state_nx = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: the image RAM has no reset; its contents must survive a reset.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_addr[AW-1:0]] <= wr_data;
    if (issue) ram_q <= mem[raddr];
  end

  // Fetch-side raster position in output geometry, plus the RAM address of the next interior pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fcol       <= '0;
      frow       <= '0;
      raddr      <= '0;
      fetch_done <= 1'b0;
      rd_pending <= 1'b0;
      rd_zero    <= 1'b0;
    end else begin
      rd_pending <= issue;
      if (issue) rd_zero <= f_border;
      if (state == S_IDLE) begin
        fcol       <= '0;
        frow       <= '0;
        raddr      <= '0;
        fetch_done <= 1'b0;
      end else if (issue) begin
        if (fcol == CW'(OUT_W - 1)) begin
          fcol <= '0;
          frow <= f_last ? '0 : frow + RW'(1);
        end else begin
          fcol <= fcol + CW'(1);
        end
        if (!f_border) raddr <= raddr + AW'(1);
        if (f_last)    fetch_done <= 1'b1;
      end
    end
  end

  assign in_data = rd_zero ? '0 : ram_q;

  // Output register backed by one skid entry that catches the read in flight during a stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!pix_valid || xfer) begin
      if (skid_valid) begin
        pix_valid  <= 1'b1;
        pix_data   <= skid_data;
        skid_valid <= rd_pending;
        if (rd_pending) skid_data <= in_data;
      end else begin
        pix_valid <= rd_pending;
        if (rd_pending) pix_data <= in_data;
      end
    end else if (rd_pending) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

  // Output-side position; advances only on a handshake and drives the markers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ocol <= '0;
      orow <= '0;
    end else if (xfer) begin
      if (ocol == CW'(OUT_W - 1)) begin
        ocol <= '0;
        orow <= o_last ? '0 : orow + RW'(1);
      end else begin
        ocol <= ocol + CW'(1);
      end
    end
  end

  assign pix_sof = pix_valid && (ocol == '0) && (orow == '0);
  assign pix_eol = pix_valid && (ocol == CW'(OUT_W - 1));
  assign pix_eof = pix_valid && o_last;

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Scoreboard bench for image_pixel_streamer on a 4x3 image; expected frames are pushed at start
// and a negedge monitor pops/compares each handshake. Honours PIXEL_STREAMER_PAD_EN.
module tb_image_pixel_streamer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
`ifdef PIXEL_STREAMER_PAD_EN
  localparam int OW = W + 2;
  localparam int OH = H + 2;
`else
  localparam int OW = W;
  localparam int OH = H;
`endif
  localparam int NOUT = OW * OH;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  logic        clock, reset, wr_en, start, pix_ready;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data, pix_data;
  logic        busy, pix_valid, pix_sof, pix_eol, pix_eof, frame_done;

  image_pixel_streamer #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(14)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .frame_done(frame_done)
  );

  pix_t       exp_q[$];
  logic [7:0] ram_m [N];
  int         n_checks = 0, n_fail = 0;
  int         xfer_count = 0, done_count = 0, cyc = 0, sof_cyc = 0, eof_cyc = 0;
  logic       exp_done = 1'b0, stalled = 1'b0;
  pix_t       held;
  int         ready_mode = 0, ready_ph = 0;
  logic [3:0] ready_pat = 4'b1001;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready driver: constant 1, or the repeating 1,0,0,1 pattern.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (ready_mode != 0) begin
        pix_ready = ready_pat[ready_ph];
        ready_ph  = (ready_ph + 1) % 4;
      end else begin
        pix_ready = 1'b1;
      end
    end
  end

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge clock) begin
    pix_t cur, e;
    cur = '{data: pix_data, sof: pix_sof, eol: pix_eol, eof: pix_eof};
    check("frame_done", 32'(frame_done), 32'(exp_done));
    exp_done = 1'b0;
    if (frame_done) begin
      done_count++;
      check("busy_at_done", 32'(busy), 0);
    end
    if (!pix_valid) check("markers_idle", {pix_sof, pix_eol, pix_eof}, 0);
    if (stalled && !reset) begin
      check("stall_valid", 32'(pix_valid), 1);
      check("stall_hold", 32'(cur), 32'(held));
    end
    if (pix_valid && pix_ready) begin
      check("pixel_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pixel", 32'(cur), 32'(e));
        if (e.sof) sof_cyc = cyc;
        if (e.eof) begin
          eof_cyc  = cyc;
          exp_done = 1'b1;
        end
      end
      xfer_count++;
      stalled = 1'b0;
    end else if (pix_valid) begin
      stalled = 1'b1;
      held    = cur;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic push_frame();
    pix_t p;
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c++) begin
        p.sof = (r == 0) && (c == 0);
        p.eol = (c == OW - 1);
        p.eof = (r == OH - 1) && (c == OW - 1);
`ifdef PIXEL_STREAMER_PAD_EN
        if (r == 0 || r == OH - 1 || c == 0 || c == OW - 1) p.data = 8'h00;
        else p.data = ram_m[(r - 1) * W + (c - 1)];
`else
        p.data = ram_m[r * W + c];
`endif
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic ram_write(input logic [13:0] a, input logic [7:0] d);
    @(posedge clock);
    #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_xfers(input int tgt, input int budget);
    int n = 0;
    while (xfer_count < tgt && n < budget) begin
      @(posedge clock);
      n++;
    end
    check("xfer_wait", 32'(xfer_count >= tgt), 1);
  endtask

  task automatic wait_done(input int tgt, input int budget);
    int n = 0;
    while (done_count < tgt && n < budget) begin
      @(posedge clock);
      n++;
    end
    check("done_wait", done_count, tgt);
  endtask

  task automatic end_of_frame(input string name, input int x0, input int d0);
    repeat (4) @(posedge clock);
    #1;
    check({name, "_xfers"}, xfer_count - x0, NOUT);
    check({name, "_dones"}, done_count - d0, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int x0, d0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {busy, pix_valid, pix_sof, pix_eol, pix_eof, frame_done, pix_data}, 0);
    reset = 1'b0;

    for (int i = 0; i < N; i++) begin
      ram_write(14'(i), 8'(i + 1));
      ram_m[i] = 8'(i + 1);
    end

    // Continuous ready: latency, back-to-back stream, done timing.
    x0 = xfer_count; d0 = done_count;
    push_frame();
    pulse_start();
    check("busy_after_start", 32'(busy), 1);
    check("no_valid_cycle1", 32'(pix_valid), 0);
    @(posedge clock);
    #1 check("no_valid_cycle2", 32'(pix_valid), 0);
    @(posedge clock);
    #1 check("first_valid", {pix_valid, pix_sof, pix_data}, {1'b1, 1'b1, 8'(OW == W ? 1 : 0)});
    wait_done(d0 + 1, 200);
    check("no_bubbles", eof_cyc - sof_cyc, NOUT - 1);
    end_of_frame("cont", x0, d0);

    // Ready toggled 1,0,0,1: stalls must hold data and markers.
    x0 = xfer_count; d0 = done_count;
    ready_ph = 0; ready_mode = 1;
    push_frame();
    pulse_start();
    wait_done(d0 + 1, 400);
    ready_mode = 0;
    end_of_frame("stall", x0, d0);

    // start and wr_en while busy are ignored.
    x0 = xfer_count; d0 = done_count;
    push_frame();
    pulse_start();
    wait_xfers(x0 + 4, 200);
    #1;
    start = 1'b1; wr_en = 1'b1; wr_addr = 14'd0; wr_data = 8'hFF;
    @(posedge clock);
    #1;
    start = 1'b0; wr_en = 1'b0;
    wait_done(d0 + 1, 200);
    end_of_frame("busy_ignore", x0, d0);

    // Second frame sees RAM[0] unchanged; a start during the DONE cycle is ignored.
    x0 = xfer_count; d0 = done_count;
    push_frame();
    pulse_start();
    wait_xfers(x0 + NOUT, 200);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (6) @(posedge clock);
    #1 check("done_start_ignored", {busy, pix_valid}, 0);
    end_of_frame("replay", x0, d0);

    // Reset after the 6th transfer aborts the frame.
    x0 = xfer_count; d0 = done_count;
    push_frame();
    pulse_start();
    wait_xfers(x0 + 6, 200);
    #1 reset = 1'b1;
    #1 check("abort_outputs", {busy, pix_valid, pix_sof, pix_eol, pix_eof, frame_done, pix_data}, 0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (8) @(posedge clock);
    #1 check("abort_no_done", done_count - d0, 0);
    check("abort_xfers", xfer_count - x0, 6);
    x0 = xfer_count;
    push_frame();
    pulse_start();
    wait_done(d0 + 1, 200);
    end_of_frame("after_reset", x0, d0);

    // Out-of-range write is dropped.
    ram_write(14'd12, 8'hAA);
    x0 = xfer_count; d0 = done_count;
    push_frame();
    pulse_start();
    wait_done(d0 + 1, 200);
    end_of_frame("oor_write", x0, d0);

    // start together with a write in IDLE: the new pixel is in this frame.
    x0 = xfer_count; d0 = done_count;
    ram_m[3] = 8'h55;
    push_frame();
    @(posedge clock);
    #1;
    start = 1'b1; wr_en = 1'b1; wr_addr = 14'd3; wr_data = 8'h55;
    @(posedge clock);
    #1;
    start = 1'b0; wr_en = 1'b0;
    wait_done(d0 + 1, 200);
    end_of_frame("start_write", x0, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_pixel_streamer.md
Name: image_pixel_streamer

Overview:
- Frame source feeding the convolution/systolic datapath.
- Holds one grayscale image in an internal RAM, loaded through a write port from the testbench or a loader.
- On a start pulse, streams the image in raster order (row 0 col 0 first) over a valid/ready interface with start-of-frame, end-of-line and end-of-frame markers.
- Read-side counterpart of the pixel sink that dumps convolution output.

Parameters:
- IMG_W, 100, pixels per line (≥2)
- IMG_H, 100, lines per frame (≥2)
- PIX_W, 8, bits per pixel
- ADDR_W, 14, RAM address width; must satisfy 2**ADDR_W ≥ IMG_W*IMG_H

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  RAM write strobe; honoured only when busy=0
- wr_addr  in  ADDR_W  write address, raster index row*IMG_W+col
- wr_data  in  PIX_W  write pixel
- start  in  1  start a frame; honoured only when busy=0
- busy  out  1  high from accepted start until frame_done
- pix_data  out  PIX_W  output pixel
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream accept
- pix_sof  out  1  qualifies first pixel of frame
- pix_eol  out  1  qualifies last pixel of each line
- pix_eof  out  1  qualifies last pixel of frame
- frame_done  out  1  one-cycle pulse after last pixel handshake

Behaviour:
- Reset (async assert, sync release): busy, pix_valid, pix_sof, pix_eol, pix_eof, frame_done = 0; pix_data = 0.
  - Row/col counters and FSM return to IDLE.
  - RAM contents are NOT cleared.
  - Reset mid-frame aborts the frame: no frame_done pulse, no further pixels.
- RAM: single write port, synchronous read with 1-cycle latency. Writes with wr_addr ≥ IMG_W*IMG_H are ignored.
- Handshake: a transfer occurs on a rising edge with pix_valid=1 and pix_ready=1.
  - While pix_valid=1 and pix_ready=0, pix_data and all markers hold stable.
  - pix_valid never drops before its transfer.
- Sideband markers are valid only while pix_valid=1 and are 0 otherwise.
- FSM states:
  - IDLE: busy=0. start=1 → FETCH; busy=1 from the next cycle.
  - FETCH: issue read of index 0 → STREAM.
  - STREAM: internal 2-entry skid buffer keeps RAM prefetch running, allowing one pixel per cycle with ready held high.
    - First pix_valid appears 2 cycles after the start edge.
    - After a transfer of pixel k, pixel k+1 is presented on the next cycle if ready stayed high.
    - Exactly IMG_W*IMG_H transfers per frame, no bubbles under continuous ready.
    - After the transfer carrying pix_eof → DONE.
  - DONE: frame_done=1 for one cycle, busy=0 in the same cycle → IDLE.
- Markers:
  - pix_sof=1 on index 0.
  - pix_eol=1 when col=IMG_W-1.
  - pix_eof=1 on index IMG_W*IMG_H-1, which also carries eol.
- Counters: col wraps IMG_W-1→0 and increments row; row wraps to 0 at frame end. Both advance only on handshake.
- Simultaneous events:
  - start while busy=1 (including the DONE cycle): ignored.
  - wr_en while busy=1: ignored, RAM unchanged.
  - start and wr_en together in IDLE: the write is performed and the frame starts. The written pixel is visible in this frame.

Optional Feature:
- Macro: PIXEL_STREAMER_PAD_EN.
- Defined: frame is emitted with a 1-pixel zero border, i.e. (IMG_W+2) x (IMG_H+2) pixels.
  - Border pixels carry pix_data=0 and do not read the RAM.
  - Interior pixel (r+1,c+1) = RAM[r*IMG_W+c].
  - sof/eol/eof refer to the padded geometry.
  - Latency and throughput rules are unchanged.
- Undefined: unpadded IMG_W x IMG_H frame exactly as above.

Test Plan:
- IMG_W=4, IMG_H=3; load RAM[i]=i+1 for i=0..11; pulse start; ready held 1 → pix_valid 2 cycles after start.
  - Data sequence is 1..12 on 12 consecutive cycles.
  - sof on 1; eol on 4, 8, 12; eof on 12.
  - frame_done pulses the cycle after 12, busy falls with it.
- Same load, pix_ready toggled 1,0,0,1 repeating → still exactly 12 transfers in order 1..12.
  - Data and markers stable through every stall, frame_done once.
- Pulse start at the 5th transfer, and wr_en to addr 0 with 0xFF mid-frame → stream unaffected (1..12).
  - A second start after done yields RAM[0]=1 again.
- Assert reset after the 6th transfer → all outputs 0 within the same cycle, busy=0, no frame_done.
  - A subsequent start replays 1..12 from index 0.
- Write to addr 12 (out of range) then stream → output identical to the first scenario.
- With PIXEL_STREAMER_PAD_EN → 30 pixels.
  - First row all 0; second row 0,1,2,3,4,0; last row all 0.
  - eol every 6th pixel; eof on the 30th pixel.
